// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer path.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  // Launch sequencer state encodings.
  localparam logic [0:0] TXF_IDLE      = 1'b0;
  localparam logic [0:0] TXF_WAIT_DONE = 1'b1;

endpackage

// File: rtl/uart_fifo_ram.sv
// Circular byte store for the UART TX buffer: storage, pointers, occupancy
// count and registered full/empty flags. Pushes while full and pops while
// empty are ignored here, so callers may present raw requests.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         i_Clock,
  input  logic                         i_Rst_L,
  input  logic                         i_Push,
  input  logic                         i_Pop,
  input  logic [UART_BYTE_W-1:0]       i_Data,
  output logic [UART_BYTE_W-1:0]       o_Data,
  output logic                         o_Full,
  output logic                         o_Empty,
  output logic [$clog2(DEPTH):0]       o_Count_Next
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [UART_BYTE_W-1:0] r_Mem [DEPTH];
  logic [AW-1:0]          r_Wr_Ptr;
  logic [AW-1:0]          r_Rd_Ptr;
  logic [CW-1:0]          r_Count;
  logic                   r_Full;
  logic                   r_Empty;
  logic                   w_Push;
  logic                   w_Pop;
  logic [CW-1:0]          w_Count_Next;

  // Qualify requests against the registered flags and form the next count.
  always_comb begin
    w_Push       = i_Push && !r_Full;
    w_Pop        = i_Pop && !r_Empty;
    w_Count_Next = r_Count + CW'(w_Push) - CW'(w_Pop);
  end

  // Pointers, count and flags; flags are registered from the next count.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
      r_Full   <= 1'b0;
      r_Empty  <= 1'b1;
    end else begin
      if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
      if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + AW'(1);
      r_Count <= w_Count_Next;
      r_Full  <= (w_Count_Next == CW'(DEPTH));
      r_Empty <= (w_Count_Next == '0);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge i_Clock) begin
    if (w_Push) r_Mem[r_Wr_Ptr] <= i_Data;
  end

  assign o_Data       = r_Mem[r_Rd_Ptr];
  assign o_Full       = r_Full;
  assign o_Empty      = r_Empty;
  assign o_Count_Next = w_Count_Next;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART TX byte buffer and launch sequencer. Buffers host writes and hands
// bytes to the transmitter one at a time, waiting for its done pulse.
// Optional macro UART_TX_FIFO_LEVEL_EN adds o_Level and o_Almost_Full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic                   o_Overflow,
  output logic                   o_TX_DV,
  output logic [UART_BYTE_W-1:0] o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic                   o_Busy
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] o_Level,
  output logic                   o_Almost_Full
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH >= DEPTH) begin : g_bad_thresh
    $error("uart_tx_fifo: AF_THRESH must lie in 1..DEPTH-1");
  end

  logic                   w_Full;
  logic                   w_Empty;
  logic [UART_BYTE_W-1:0] w_Head;
  logic [CW-1:0]          w_Count_Next;
  logic                   w_Pop;
  logic [0:0]             w_State_Next;

  logic [0:0]             r_State;
  logic                   r_TX_DV;
  logic [UART_BYTE_W-1:0] r_TX_Byte;
  logic                   r_Overflow;
  logic                   r_Busy;

  uart_fifo_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .i_Clock      (i_Clock),
    .i_Rst_L      (i_Rst_L),
    .i_Push       (i_Wr_DV),
    .i_Pop        (w_Pop),
    .i_Data       (i_Wr_Byte),
    .o_Data       (w_Head),
    .o_Full       (w_Full),
    .o_Empty      (w_Empty),
    .o_Count_Next (w_Count_Next)
  );

  // Launch decision: pop from IDLE when the line is free, or chain the next
  // byte straight off a done pulse while waiting.
  always_comb begin
    w_Pop        = 1'b0;
    w_State_Next = r_State;
    case (r_State)
      TXF_IDLE: begin
        if (!w_Empty && !i_TX_Active) begin
          w_Pop        = 1'b1;
          w_State_Next = TXF_WAIT_DONE;
        end
      end
      TXF_WAIT_DONE: begin
        if (i_TX_Done) begin
          if (!w_Empty) w_Pop = 1'b1;
          else          w_State_Next = TXF_IDLE;
        end
      end
      default: w_State_Next = TXF_IDLE;
    endcase
  end

  // Sequencer state, transmitter handoff registers and status flags.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_State    <= TXF_IDLE;
      r_TX_DV    <= 1'b0;
      r_TX_Byte  <= '0;
      r_Overflow <= 1'b0;
      r_Busy     <= 1'b0;
    end else begin
      r_State    <= w_State_Next;
      r_TX_DV    <= w_Pop;
      if (w_Pop) r_TX_Byte <= w_Head;
      r_Overflow <= i_Wr_DV && w_Full;
      r_Busy     <= (w_Count_Next != '0) || (w_State_Next == TXF_WAIT_DONE);
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [CW-1:0] r_Level;
  logic          r_Almost_Full;

  // Registered occupancy and almost-full indication.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_Level       <= '0;
      r_Almost_Full <= 1'b0;
    end else begin
      r_Level       <= w_Count_Next;
      r_Almost_Full <= (w_Count_Next >= CW'(AF_THRESH));
    end
  end

  assign o_Level       = r_Level;
  assign o_Almost_Full = r_Almost_Full;
`endif

  assign o_Full     = w_Full;
  assign o_Empty    = w_Empty;
  assign o_Overflow = r_Overflow;
  assign o_TX_DV    = r_TX_DV;
  assign o_TX_Byte  = r_TX_Byte;
  assign o_Busy     = r_Busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writer pushes expected bytes and timed
// expectations, a transmitter model answers launches, a monitor compares.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       i_Clock = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Wr_DV = 1'b0;
  logic [7:0] i_Wr_Byte = 8'h00;
  logic       i_TX_Active = 1'b0;
  logic       i_TX_Done = 1'b0;
  logic       o_Full, o_Empty, o_Overflow, o_TX_DV, o_Busy;
  logic [7:0] o_TX_Byte;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] o_Level;
  logic                   o_Almost_Full;
`endif

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .AF_THRESH(12)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_Wr_DV     (i_Wr_DV),
    .i_Wr_Byte   (i_Wr_Byte),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Overflow  (o_Overflow),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done),
    .o_Busy      (o_Busy)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .o_Level       (o_Level),
    .o_Almost_Full (o_Almost_Full)
`endif
  );

  always #5 i_Clock = ~i_Clock;

  typedef enum int {K_DV, K_EMPTY, K_FULL, K_BUSY} kind_t;
  typedef struct {
    int    cyc;
    kind_t kind;
    logic  val;
  } chk_t;

  chk_t       chkq[$];
  logic [7:0] expq[$];
  int         cyc = 0;
  int         n_acc = 0;
  int         n_launch = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         tx_left = 0;
  int         tx_len = 20;
  bit         tx_stall = 1'b0;
  int         ovf_cyc = -1;
  logic       prev_dv = 1'b0;
  logic       prev_rst_l = 1'b0;
  logic       prev_wr = 1'b0;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge i_Clock);
    cyc++;
  end

  // Monitor: compares launched bytes, hold, overflow, reset state, timed checks.
  initial forever begin
    @(negedge i_Clock);
    if (!prev_rst_l) begin
      check("rst_empty", int'(o_Empty), 1);
      check("rst_full", int'(o_Full), 0);
      check("rst_dv", int'(o_TX_DV), 0);
      check("rst_busy", int'(o_Busy), 0);
      check("rst_byte", int'(o_TX_Byte), 0);
      check("rst_ovf", int'(o_Overflow), 0);
      last_byte = 8'h00;
    end else begin
      if (o_TX_DV) begin
        check("dv_gap", int'(prev_dv), 0);
        if (expq.size() == 0) check("dv_unexpected", int'(o_TX_DV), 0);
        else check("tx_byte", int'(o_TX_Byte), int'(expq.pop_front()));
        n_launch++;
        last_byte = o_TX_Byte;
      end else begin
        check("byte_hold", int'(o_TX_Byte), int'(last_byte));
      end
      check("overflow", int'(o_Overflow), int'(cyc == ovf_cyc));
    end
    for (int i = chkq.size() - 1; i >= 0; i--) begin
      if (chkq[i].cyc == cyc) begin
        chk_t c;
        c = chkq[i];
        chkq.delete(i);
        case (c.kind)
          K_DV:    check("dv_timing", int'(o_TX_DV), int'(c.val));
          K_EMPTY: check("empty_timing", int'(o_Empty), int'(c.val));
          K_FULL:  check("full_flag", int'(o_Full), int'(c.val));
          K_BUSY:  if (!prev_wr) check("busy_fall", int'(o_Busy), int'(c.val));
          default: ;
        endcase
      end
    end
    prev_dv    = o_TX_DV;
    prev_rst_l = i_Rst_L;
    prev_wr    = i_Wr_DV;
  end

  // Transmitter model: active for tx_len cycles after a launch, then done.
  initial forever begin
    int pending;
    @(posedge i_Clock);
    #1;
    i_TX_Done = 1'b0;
    if (!i_Rst_L) begin
      tx_left = 0;
    end else if (prev_dv) begin
      tx_left = tx_len - 1;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        i_TX_Done = 1'b1;
        pending = n_acc - n_launch;
        chkq.push_back('{cyc + 1, K_DV, pending > 0});
        if (pending == 0) chkq.push_back('{cyc + 1, K_BUSY, 1'b0});
      end
    end
    i_TX_Active = tx_stall || (tx_left > 0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #2;
      i_Wr_DV = 1'b0;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    int occ;
    bit quiet;
    @(posedge i_Clock);
    #2;
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = b;
    occ   = n_acc - n_launch;
    quiet = (occ == 0) && (tx_left == 0) && !tx_stall && !i_TX_Active;
    if (occ < DEPTH) begin
      expq.push_back(b);
      n_acc++;
      if (quiet) begin
        chkq.push_back('{cyc + 1, K_EMPTY, 1'b0});
        chkq.push_back('{cyc + 2, K_DV, 1'b1});
      end
      if (tx_stall) chkq.push_back('{cyc + 1, K_FULL, (occ + 1) == DEPTH});
    end else begin
      ovf_cyc = cyc + 1;
      if (tx_stall) chkq.push_back('{cyc + 1, K_FULL, 1'b1});
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge i_Clock);
    #2;
    i_Rst_L = 1'b0;
    i_Wr_DV = 1'b0;
    expq.delete();
    chkq.delete();
    n_acc    = 0;
    n_launch = 0;
    ovf_cyc  = -1;
    repeat (n) begin
      @(posedge i_Clock);
      #2;
    end
    i_Rst_L = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || tx_left != 0 || chkq.size() != 0) && t < 3000) begin
      idle(1);
      t++;
    end
    if (t >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout cyc=%0d got=%0d queued expected=0", cyc, expq.size());
    end
    idle(3);
  endtask

  initial begin
    int w;
    do_reset(3);
    idle(2);

    tx_len = 20;
    wr(8'hA5);
    idle(1);
    drain();

    for (int i = 1; i <= 4; i++) wr(8'(i));
    idle(1);
    drain();

    tx_stall = 1'b1;
    idle(3);
    for (int i = 0; i < 17; i++) wr(8'(8'h40 + i));
    idle(2);
    tx_stall = 1'b0;
    drain();

    tx_len = 3;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) wr(8'(8'h80 + 10 * r + i));
      idle(1);
      drain();
    end

    tx_len = 20;
    for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
    idle(1);
    w = 0;
    while (n_launch == 0 && w < 50) begin
      idle(1);
      w++;
    end
    if (w >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL launch_timeout cyc=%0d got=0 launches expected=1", cyc);
    end
    idle(5);
    do_reset(1);
    idle(30);
    wr(8'h5A);
    idle(1);
    drain();

    for (int k = 0; k < 400; k++) begin
      tx_len = $urandom_range(2, 8);
      if ($urandom_range(0, 2) != 0 && (n_acc - n_launch) < DEPTH - 2)
        wr(8'($urandom));
      else
        idle(1);
    end
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
